// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one DIGIT-wide ripple group is reused over
// N = WIDTH/DIGIT cycles, with a start/busy/done handshake and held results.
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_ps;
  logic             r_carry;
  logic [CW-1:0]    r_count;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic [DIGIT:0]   w_c;
  logic [DIGIT-1:0] w_dsum;
  logic [WIDTH-1:0] w_ps_next;
  logic             w_last;
  logic             w_load;

  // Ripple group over the low DIGIT bits; w_c[DIGIT-1] is the carry into the
  // group's top bit, which on the final digit is the carry into bit WIDTH-1.
  assign w_c[0] = r_carry;
  generate
    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_ripple
      assign w_dsum[gi]  = r_a[gi] ^ r_b[gi] ^ w_c[gi];
      assign w_c[gi + 1] = (r_a[gi] & r_b[gi]) | (w_c[gi] & (r_a[gi] ^ r_b[gi]));
    end
    if (DIGIT == WIDTH) begin : g_ps_full
      assign w_ps_next = w_dsum;
    end else begin : g_ps_shift
      assign w_ps_next = {w_dsum, r_ps[WIDTH-1:DIGIT]};
    end
  endgenerate

  assign w_last = (r_count == CW'(N - 1));
  assign w_load = start && (r_state != RUN);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = RUN;
      RUN:     if (w_last) w_state_next = DONE;
      DONE:    w_state_next = start ? RUN : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_ps    <= '0;
      r_carry <= 1'b0;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_busy <= (w_state_next == RUN);
      r_done <= (w_state_next == DONE);
      if (w_load) begin
        // Subtraction is a + ~b + 1: invert B and seed the carry with 1.
        r_a     <= a;
        r_b     <= sub ? ~b : b;
        r_carry <= sub;
        r_count <= '0;
      end else if (r_state == RUN) begin
        r_a     <= r_a >> DIGIT;
        r_b     <= r_b >> DIGIT;
        r_ps    <= w_ps_next;
        r_carry <= w_c[DIGIT];
        r_count <= r_count + CW'(1);
        if (w_last) begin
          r_sum  <= w_ps_next;
          r_cout <= w_c[DIGIT];
          r_ovf  <= w_c[DIGIT] ^ w_c[DIGIT-1];
        end
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: five configurations checked every cycle against an
// arithmetic reference model, plus directed literal expectations.
module tb_serial_addsub;

  localparam int NI = 5;
  localparam int W_T [NI] = '{4, 8, 8, 16, 16};
  localparam int N_T [NI] = '{4, 8, 2, 8, 1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        st [NI];
  logic        sb [NI];
  logic [15:0] av [NI];
  logic [15:0] bv [NI];
  logic        bz [NI];
  logic        dn [NI];
  logic        co [NI];
  logic        ov [NI];
  logic [3:0]  s0;
  logic [7:0]  s1, s2;
  logic [15:0] s3, s4;

  int total = 0;
  int bad   = 0;

  serial_addsub #(.WIDTH(4), .DIGIT(1)) u0 (
    .clk(clk), .rst(rst), .start(st[0]), .sub(sb[0]), .a(av[0][3:0]), .b(bv[0][3:0]),
    .busy(bz[0]), .done(dn[0]), .sum(s0), .cout(co[0]), .ovf(ov[0]));
  serial_addsub #(.WIDTH(8), .DIGIT(1)) u1 (
    .clk(clk), .rst(rst), .start(st[1]), .sub(sb[1]), .a(av[1][7:0]), .b(bv[1][7:0]),
    .busy(bz[1]), .done(dn[1]), .sum(s1), .cout(co[1]), .ovf(ov[1]));
  serial_addsub #(.WIDTH(8), .DIGIT(4)) u2 (
    .clk(clk), .rst(rst), .start(st[2]), .sub(sb[2]), .a(av[2][7:0]), .b(bv[2][7:0]),
    .busy(bz[2]), .done(dn[2]), .sum(s2), .cout(co[2]), .ovf(ov[2]));
  serial_addsub #(.WIDTH(16), .DIGIT(2)) u3 (
    .clk(clk), .rst(rst), .start(st[3]), .sub(sb[3]), .a(av[3]), .b(bv[3]),
    .busy(bz[3]), .done(dn[3]), .sum(s3), .cout(co[3]), .ovf(ov[3]));
  serial_addsub #(.WIDTH(16), .DIGIT(16)) u4 (
    .clk(clk), .rst(rst), .start(st[4]), .sub(sb[4]), .a(av[4]), .b(bv[4]),
    .busy(bz[4]), .done(dn[4]), .sum(s4), .cout(co[4]), .ovf(ov[4]));

  function automatic logic [15:0] get_sum(int d);
    case (d)
      0:       return {12'h000, s0};
      1:       return {8'h00, s1};
      2:       return {8'h00, s2};
      3:       return s3;
      default: return s4;
    endcase
  endfunction

  // Reference result {cout, ovf, sum} from plain integer arithmetic.
  function automatic logic [17:0] ref_op(int w, logic [15:0] a, logic [15:0] b, logic s);
    longint m  = longint'(1) << w;
    longint ua = longint'(a) & (m - 1);
    longint ub = longint'(b) & (m - 1);
    longint sa = (ua >= m / 2) ? ua - m : ua;
    longint sg = (ub >= m / 2) ? ub - m : ub;
    longint r  = s ? ua - ub : ua + ub;
    longint rs = ((r % m) + m) % m;
    longint sr = s ? sa - sg : sa + sg;
    logic   rc = s ? (ua >= ub) : (r >= m);
    logic   ro = (sr < -(m / 2)) || (sr > (m / 2) - 1);
    return {rc, ro, rs[15:0]};
  endfunction

  task automatic chk(string nm, int d, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s inst=%0d got=%0h want=%0h t=%0t", nm, d, act, exp, $time);
    end
  endtask

  // Model state: cycles left in the operation, done pulse, held and pending results.
  int          m_cnt  [NI];
  logic        m_done [NI];
  logic [17:0] m_res  [NI];
  logic [17:0] p_res  [NI];

  initial begin
    for (int d = 0; d < NI; d++) begin
      m_cnt[d] = 0; m_done[d] = 1'b0; m_res[d] = '0; p_res[d] = '0;
      st[d] = 1'b0; sb[d] = 1'b0; av[d] = '0; bv[d] = '0;
    end
  end

  always @(posedge clk) begin
    for (int d = 0; d < NI; d++) begin
      if (rst) begin
        m_cnt[d]  <= 0;
        m_done[d] <= 1'b0;
        m_res[d]  <= '0;
      end else if (m_cnt[d] > 0) begin
        m_cnt[d]  <= m_cnt[d] - 1;
        m_done[d] <= (m_cnt[d] == 1);
        if (m_cnt[d] == 1) m_res[d] <= p_res[d];
      end else begin
        m_done[d] <= 1'b0;
        if (st[d]) begin
          m_cnt[d] <= N_T[d];
          p_res[d] <= ref_op(W_T[d], av[d], bv[d], sb[d]);
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < NI; d++) begin
      chk("busy", d, longint'(bz[d]), longint'(m_cnt[d] > 0));
      chk("done", d, longint'(dn[d]), longint'(m_done[d]));
      chk("sum",  d, longint'(get_sum(d)), longint'(m_res[d][15:0]));
      chk("ovf",  d, longint'(ov[d]), longint'(m_res[d][16]));
      chk("cout", d, longint'(co[d]), longint'(m_res[d][17]));
    end
  end

  task automatic launch(int d, logic [15:0] a, logic [15:0] b, logic s);
    av[d] = a; bv[d] = b; sb[d] = s; st[d] = 1'b1;
    @(posedge clk); #1;
    st[d] = 1'b0;
  endtask

  task automatic wait_done(int d, output int lat);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      lat++;
      if (dn[d]) break;
    end
    chk("done_seen", d, longint'(dn[d]), 1);
    $display("op inst=%0d a=%0h b=%0h sub=%0d -> sum=%0h cout=%0d ovf=%0d lat=%0d",
             d, av[d], bv[d], sb[d], get_sum(d), co[d], ov[d], lat);
  endtask

  task automatic op(int d, logic [15:0] a, logic [15:0] b, logic s, output int lat);
    launch(d, a, b, s);
    wait_done(d, lat);
  endtask

  task automatic expect_res(string nm, int d, logic [15:0] es, logic ec, logic eo);
    chk({nm, "_sum"},  d, longint'(get_sum(d)), longint'(es));
    chk({nm, "_cout"}, d, longint'(co[d]), longint'(ec));
    chk({nm, "_ovf"},  d, longint'(ov[d]), longint'(eo));
  endtask

  initial begin
    int lat;
    int last;
    int pulses;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_busy", 1, longint'(bz[1]), 0);
    chk("rst_sum",  1, longint'(get_sum(1)), 0);

    // Exhaustive 4-bit add
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        op(0, 16'(x), 16'(y), 1'b0, lat);
        chk("w4_lat", 0, lat, 4);
        chk("w4_cs", 0, longint'({co[0], s0}), longint'(x + y));
      end
    end
    op(0, 16'h7, 16'h1, 1'b0, lat);
    expect_res("w4_7p1", 0, 16'h8, 1'b0, 1'b1);

    // 8-bit subtract
    op(1, 16'h05, 16'h07, 1'b1, lat);
    expect_res("sub_5m7", 1, 16'hFE, 1'b0, 1'b0);
    op(1, 16'h80, 16'h01, 1'b1, lat);
    expect_res("sub_80m1", 1, 16'h7F, 1'b1, 1'b1);
    op(1, 16'h10, 16'h10, 1'b1, lat);
    expect_res("sub_10m10", 1, 16'h00, 1'b1, 1'b0);

    // DIGIT=4
    op(2, 16'hFF, 16'h01, 1'b0, lat);
    chk("d4_lat", 2, lat, 2);
    expect_res("d4_ffp1", 2, 16'h00, 1'b1, 1'b0);
    op(2, 16'h7F, 16'h01, 1'b0, lat);
    expect_res("d4_7fp1", 2, 16'h80, 1'b0, 1'b1);

    // start during RUN is ignored
    launch(1, 16'h12, 16'h34, 1'b0);
    repeat (2) @(posedge clk);
    #1 launch(1, 16'hFF, 16'hFF, 1'b1);
    wait_done(1, lat);
    expect_res("ignore", 1, 16'h46, 1'b0, 1'b0);

    // result holds while the next operation runs
    launch(1, 16'h01, 16'h01, 1'b0);
    repeat (3) @(posedge clk);
    #1 chk("hold_sum", 1, longint'(get_sum(1)), 16'h46);
    chk("hold_busy", 1, longint'(bz[1]), 1);
    wait_done(1, lat);
    expect_res("hold_next", 1, 16'h02, 1'b0, 1'b0);

    // start held high: done every N+1 cycles, busy low only when done
    av[1] = 16'h03; bv[1] = 16'h04; sb[1] = 1'b0; st[1] = 1'b1;
    last = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      chk("b2b_busy", 1, longint'(bz[1]), longint'(!dn[1]));
      if (dn[1]) begin
        if (last >= 0) chk("b2b_gap", 1, i - last, 9);
        last = i;
      end
    end
    st[1] = 1'b0;
    wait_done(1, lat);

    // reset mid-operation
    op(1, 16'h20, 16'h01, 1'b0, lat);
    launch(1, 16'h55, 16'h22, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_busy", 1, longint'(bz[1]), 0);
    chk("mid_rst_done", 1, longint'(dn[1]), 0);
    expect_res("mid_rst", 1, 16'h00, 1'b0, 1'b0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (dn[1]) pulses++;
    end
    chk("mid_rst_nodone", 1, pulses, 0);

    // random at WIDTH=16, DIGIT=2 and DIGIT=16
    for (int d = 3; d < NI; d++) begin
      for (int i = 0; i < 1000; i++) begin
        op(d, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), lat);
        chk("rand_lat", d, lat, N_T[d]);
      end
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
